// File: rtl/scaler2_pkg.sv
// rtl/scaler2_pkg.sv - shared constants and helpers for the scaler2 pipeline
package scaler2_pkg;

  localparam int LINEAR_INTERP_LATENCY = 5;

  // Per-sample flags carried alongside the datapath
  typedef struct packed {
    logic de;
    logic sol;
    logic sof;
  } li_flags_t;

  function automatic int coe_one(input int coe_width);
    return 1 << (coe_width - 1);
  endfunction

  function automatic int round_const(input int coe_width);
    return 1 << (coe_width - 2);
  endfunction

endpackage

// File: rtl/linear_interp_mac.sv
// rtl/linear_interp_mac.sv - multiply/add/round/saturate stages of linear_interp (3-clk latency)
module linear_interp_mac
  import scaler2_pkg::*;
#(
  parameter int COE_WIDTH   = 10,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic                   bypass_i,
  input  logic [PIXEL_WIDTH-1:0] p_prev_i,
  input  logic [PIXEL_WIDTH-1:0] p_cur_i,
  input  logic [COE_WIDTH-1:0]   coe0_i,
  input  logic [COE_WIDTH-1:0]   coe1_i,
  output logic [PIXEL_WIDTH-1:0] do_o
);

  localparam int MW    = PIXEL_WIDTH + COE_WIDTH;
  localparam int SW    = MW + 1;
  localparam int SHIFT = $clog2(coe_one(COE_WIDTH));
  localparam int QW    = SW - SHIFT;
  localparam logic [SW-1:0] RND = SW'(round_const(COE_WIDTH));

  logic [MW-1:0]          w_prev_x, w_cur_x, w_coe0_x, w_coe1_x;
  logic [QW-1:0]          w_q;
  logic [PIXEL_WIDTH-1:0] w_sat;

  logic                   r3_v, r3_byp, r4_v, r4_byp;
  logic [PIXEL_WIDTH-1:0] r3_pix, r4_pix;
  logic [MW-1:0]          r3_m0, r3_m1;
  logic [SW-1:0]          r4_sum;

  assign w_prev_x = {{COE_WIDTH{1'b0}}, p_prev_i};
  assign w_cur_x  = {{COE_WIDTH{1'b0}}, p_cur_i};
  assign w_coe0_x = {{PIXEL_WIDTH{1'b0}}, coe0_i};
  assign w_coe1_x = {{PIXEL_WIDTH{1'b0}}, coe1_i};

  // Any bit above the pixel range means the weighted sum overshot white
  assign w_q   = r4_sum[SW-1:SHIFT];
  assign w_sat = (|w_q[QW-1:PIXEL_WIDTH]) ? '1 : w_q[PIXEL_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r3_v   <= 1'b0;
      r3_byp <= 1'b0;
      r3_pix <= '0;
      r3_m0  <= '0;
      r3_m1  <= '0;
      r4_v   <= 1'b0;
      r4_byp <= 1'b0;
      r4_pix <= '0;
      r4_sum <= '0;
      do_o   <= '0;
    end else begin
      r3_v <= valid_i;
      if (valid_i) begin
        r3_m0  <= w_prev_x * w_coe0_x;
        r3_m1  <= w_cur_x * w_coe1_x;
        r3_pix <= p_cur_i;
        r3_byp <= bypass_i;
      end
      r4_v <= r3_v;
      if (r3_v) begin
        r4_sum <= {1'b0, r3_m0} + {1'b0, r3_m1} + RND;
        r4_pix <= r3_pix;
        r4_byp <= r3_byp;
      end
      if (r4_v) begin
        do_o <= r4_byp ? r4_pix : w_sat;
      end
    end
  end

endmodule

// File: rtl/linear_interp.sv
// rtl/linear_interp.sv - horizontal linear interpolator top; LINEAR_INTERP_BYPASS_EN adds bypass_i
module linear_interp
  import scaler2_pkg::*;
#(
  parameter int STEP        = 4096,
  parameter int COE_WIDTH   = 10,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PIXEL_WIDTH-1:0]      di_i,
  input  logic                        de_i,
  input  logic                        sol_i,
  input  logic                        sof_i,
`ifdef LINEAR_INTERP_BYPASS_EN
  input  logic                        bypass_i,
`endif
  input  logic [$clog2(STEP/2)-1:0]   dx_i,
  output logic [$clog2(STEP/2)-1:0]   dx_o,
  input  logic [COE_WIDTH-1:0]        coe0_i,
  input  logic [COE_WIDTH-1:0]        coe1_i,
  output logic [PIXEL_WIDTH-1:0]      do_o,
  output logic                        de_o,
  output logic                        sol_o,
  output logic                        sof_o
);

  localparam int LAT = LINEAR_INTERP_LATENCY;

  logic                   w_byp;
  logic [PIXEL_WIDTH-1:0] r_last;
  logic                   r_first;
  logic [PIXEL_WIDTH-1:0] r1_prev, r1_cur, r2_prev, r2_cur;
  logic                   r1_byp, r2_byp;
  li_flags_t              r_flags [LAT];

`ifdef LINEAR_INTERP_BYPASS_EN
  assign w_byp = bypass_i;
`else
  assign w_byp = 1'b0;
`endif

  // r_first forces edge replication on the first pixel after reset, even without sol_i
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dx_o    <= '0;
      r_last  <= '0;
      r_first <= 1'b1;
      r1_prev <= '0;
      r1_cur  <= '0;
      r1_byp  <= 1'b0;
      r2_prev <= '0;
      r2_cur  <= '0;
      r2_byp  <= 1'b0;
      for (int i = 0; i < LAT; i++) r_flags[i] <= '0;
    end else begin
      r_flags[0] <= '{de: de_i, sol: de_i & sol_i, sof: de_i & sof_i};
      for (int i = 1; i < LAT; i++) r_flags[i] <= r_flags[i-1];
      if (de_i) begin
        dx_o    <= dx_i;
        r1_cur  <= di_i;
        r1_prev <= (sol_i || r_first) ? di_i : r_last;
        r1_byp  <= w_byp;
        r_last  <= di_i;
        r_first <= 1'b0;
      end
      if (r_flags[0].de) begin
        r2_prev <= r1_prev;
        r2_cur  <= r1_cur;
        r2_byp  <= r1_byp;
      end
    end
  end

  linear_interp_mac #(
    .COE_WIDTH  (COE_WIDTH),
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (r_flags[1].de),
    .bypass_i(r2_byp),
    .p_prev_i(r2_prev),
    .p_cur_i (r2_cur),
    .coe0_i  (coe0_i),
    .coe1_i  (coe1_i),
    .do_o    (do_o)
  );

  assign de_o  = r_flags[LAT-1].de;
  assign sol_o = r_flags[LAT-1].sol;
  assign sof_o = r_flags[LAT-1].sof;

endmodule

// File: tb/tb_linear_interp.sv
// tb/tb_linear_interp.sv - directed self-checking bench for linear_interp
module tb_linear_interp;

  localparam int DXW = 11;

  typedef struct {
    logic [7:0] d;
    logic       sol;
    logic       sof;
    int         due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     di_i;
  logic           de_i, sol_i, sof_i, bypass_i;
  logic [DXW-1:0] dx_i, dx_o;
  logic [9:0]     coe0_i, coe1_i;
  logic [7:0]     do_o;
  logic           de_o, sol_o, sof_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_on  = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient table model: 1-clk ROM indexed by dx_o
  always @(posedge clk) begin
    case (dx_o)
      11'd0:   begin coe0_i <= 10'd0;   coe1_i <= 10'd512; end
      11'd1:   begin coe0_i <= 10'd256; coe1_i <= 10'd256; end
      11'd2:   begin coe0_i <= 10'd512; coe1_i <= 10'd10;  end
      11'd3:   begin coe0_i <= 10'd512; coe1_i <= 10'd0;   end
      default: begin coe0_i <= 10'd0;   coe1_i <= 10'd0;   end
    endcase
  end

  linear_interp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .di_i    (di_i),
    .de_i    (de_i),
    .sol_i   (sol_i),
    .sof_i   (sof_i),
`ifdef LINEAR_INTERP_BYPASS_EN
    .bypass_i(bypass_i),
`endif
    .dx_i    (dx_i),
    .dx_o    (dx_o),
    .coe0_i  (coe0_i),
    .coe1_i  (coe1_i),
    .do_o    (do_o),
    .de_o    (de_o),
    .sol_o   (sol_o),
    .sof_o   (sof_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] pix, input logic [DXW-1:0] dx,
                      input logic sol, input logic sof, input logic byp,
                      input logic [7:0] exp_do);
    exp_t e;
    di_i = pix; dx_i = dx; sol_i = sol; sof_i = sof; bypass_i = byp; de_i = 1'b1;
    e.d = exp_do; e.sol = sol; e.sof = sof; e.due = cyc + 5;
    q.push_back(e);
    step();
    de_i = 1'b0; sol_i = 1'b0; sof_i = 1'b0; bypass_i = 1'b0;
  endtask

  task automatic idle(input int n, input logic [DXW-1:0] dx_noise);
    de_i = 1'b0; dx_i = dx_noise; di_i = 8'hA5;
    repeat (n) step();
  endtask

  // Output monitor: de_o must appear exactly on the due cycle of the oldest expected sample
  always @(negedge clk) begin
    if (mon_on) begin
      logic want;
      want = (q.size() > 0) && (q[0].due == cyc);
      check("de_o", de_o, want);
      if (want) begin
        check("do_o", do_o, q[0].d);
        check("sol_o", sol_o, q[0].sol);
        check("sof_o", sof_o, q[0].sof);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; de_i = 1'b0; sol_i = 1'b0; sof_i = 1'b0; bypass_i = 1'b0;
    di_i = 8'd0; dx_i = '0;
    repeat (3) step();
    check("rst do_o", do_o, 0);
    check("rst de_o", de_o, 0);
    check("rst sol_o", sol_o, 0);
    check("rst sof_o", sof_o, 0);
    check("rst dx_o", dx_o, 0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    step();

    // Line start replication then a 50/50 blend; sol and sof together
    send(8'd100, 11'd1, 1'b1, 1'b1, 1'b0, 8'd100);
    send(8'd200, 11'd1, 1'b0, 1'b0, 1'b0, 8'd150);
    // Half-way rounds up, pure current-pixel weight
    send(8'd1,   11'd1, 1'b1, 1'b0, 1'b0, 8'd1);
    send(8'd2,   11'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    send(8'd1,   11'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    send(8'd1,   11'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    // Saturation and zero
    send(8'd255, 11'd2, 1'b1, 1'b0, 1'b0, 8'd255);
    send(8'd0,   11'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    // sof alone, prev = last accepted (0)
    send(8'd50,  11'd1, 1'b0, 1'b1, 1'b0, 8'd25);

    // Gap: de 1,0,0,1; dx_o held; previous pixel held across the gap
    send(8'd10,  11'd0, 1'b1, 1'b0, 1'b0, 8'd10);
    idle(2, 11'd3);
    check("dx_o held", dx_o, 0);
    send(8'd20,  11'd1, 1'b0, 1'b0, 1'b0, 8'd15);
    idle(8, 11'd0);

    // Reset with three samples in flight
    send(8'd30,  11'd1, 1'b1, 1'b0, 1'b0, 8'd30);
    send(8'd40,  11'd1, 1'b0, 1'b0, 1'b0, 8'd35);
    send(8'd50,  11'd1, 1'b0, 1'b0, 1'b0, 8'd45);
    rst_n = 1'b0;
    q.delete();
    step();
    rst_n = 1'b1;
    check("mid-rst do_o", do_o, 0);
    check("mid-rst de_o", de_o, 0);
    check("mid-rst sol_o", sol_o, 0);
    check("mid-rst sof_o", sof_o, 0);
    check("mid-rst dx_o", dx_o, 0);
    idle(6, 11'd2);
    check("post-rst do_o", do_o, 0);
    // First pixel after reset is a line start without sol_i
    send(8'd77,  11'd1, 1'b0, 1'b0, 1'b0, 8'd77);

`ifdef LINEAR_INTERP_BYPASS_EN
    send(8'd123, 11'd2, 1'b0, 1'b0, 1'b1, 8'd123);
    send(8'd200, 11'd1, 1'b0, 1'b0, 1'b0, 8'd162);
`endif

    idle(10, 11'd0);
    check("drain", q.size(), 0);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
